nibble_change_capture: RTL
==========================

Name: nibble_change_capture

Overview:
- Downstream stage of the registered nibble-alignment block: samples its per-cycle outputs (1-bit flag plus two WIDTH-bit fields) and records only samples that differ from the last one recorded.
- Each recorded sample is stamped and buffered in a small FIFO. The FIFO drains over a valid/ready interface to a debug/trace consumer.
- Samples that cannot be stored are dropped and counted.

Parameters:
- WIDTH, 4, width of field_a_i / field_b_i and the stored fields.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- TS_W, 8, timestamp width; the timestamp counter wraps modulo 2^TS_W.
- DROP_W, 8, width of the drop counter; the counter saturates.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  capture enable
- flag_i  input  1  upstream flag (AND-reduce result)
- field_a_i  input  WIDTH  upstream field A
- field_b_i  input  WIDTH  upstream field B
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_flag  output  1  head flag
- out_a  output  WIDTH  head field A
- out_b  output  WIDTH  head field B
- out_ts  output  TS_W  head timestamp
- level  output  $clog2(DEPTH)+1  current occupancy
- drop_cnt  output  DROP_W  dropped-sample count, saturating

Behaviour:
- Reset (clk edge with rst_n=0):
  - state=IDLE, FIFO empty, level=0, out_valid=0.
  - out_flag/out_a/out_b/out_ts = 0, drop_cnt=0, timestamp counter ts=0.
  - last-recorded register = 0.
  - Reset mid-operation discards all FIFO contents.
- FSM states: IDLE, ARM, RUN.
  - IDLE: no capture; ts holds at 0. If en=1, next state is ARM.
  - ARM: the current sample is always a candidate, with no compare; ts increments. Next state is RUN, or IDLE if en=0.
  - RUN: a sample is a candidate when {flag_i,field_a_i,field_b_i} differs from the last-recorded register; ts increments each cycle.
  - RUN with en=0: the next state is IDLE and ts clears to 0. The FIFO keeps its contents and continues to drain.
  - Leaving IDLE always passes through ARM, so the first sample after enable is always recorded.
- Timestamp: the stored ts is the counter value in the cycle the sample is presented. The counter wraps 2^TS_W-1 -> 0 without a flag.
- Push rules:
  - pop = out_valid & out_ready.
  - A candidate is pushed when level<DEPTH, or when level==DEPTH and pop=1 in the same cycle (simultaneous push/pop when full is legal; level unchanged).
  - On push, the last-recorded register updates to the sample.
  - A candidate that cannot be pushed is dropped: drop_cnt increments, saturating at 2^DROP_W-1. The last-recorded register is NOT updated, so the same value is retried next cycle while it persists.
- Pop and output:
  - The FIFO is first-word-fall-through: out_* present the head combinationally from storage, and out_valid = (level != 0).
  - A push into an empty FIFO is visible on out_valid the next cycle (1-cycle latency).
  - While out_valid=1 and out_ready=0, the head fields must hold stable.
  - When out_valid=0, out_* hold their last value, or 0 after reset.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH; never underflows (pop requires out_valid).
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from level, not from the pointers.
- Inputs X while en=0 must not propagate into state.

Decomposition:
- Package nibble_capture_pkg:
  - typedef enum of the FSM states {IDLE, ARM, RUN}.
  - Parameterized packed struct sample_t {flag, a, b, ts}; alternatively provide a width-function helper if the tool flow disallows parameterized typedefs in a package.
  - Default constants for WIDTH/DEPTH/TS_W/DROP_W.
- One sub-module, capture_fifo:
  - Generic DEPTH x data-width synchronous FWFT FIFO.
  - Ports: push/pop/data/level.
  - Synchronous active-low reset.
- Top level: FSM, compare, timestamp counter and drop counter.

Test Plan:
- Reset then en=1 with a constant input {1,4'h3,4'hC} for 5 cycles, out_ready=1 -> exactly one entry with ts=1 (ARM cycle); out_valid goes high 1 cycle after ARM; drop_cnt=0.
- RUN with the input changing every cycle through 4'h0..4'h7, out_ready=0, DEPTH=4 -> four entries stored, level=4, then drop_cnt increments by 1 per cycle, 4 drops total; out_a remains 4'h0 throughout.
- FIFO full, input changing, out_ready=1 for one cycle -> the head pops and the new sample is pushed in the same cycle; level stays 4; drop_cnt unchanged.
- TS_W=3, input toggling every cycle for 12 cycles -> the stored ts sequence wraps 7 -> 0 with no glitch on the other fields.
- DROP_W=2, sustained overflow for 6 cycles -> drop_cnt saturates at 3.
- rst_n=0 asserted for one cycle with level=3 mid-drain -> next cycle level=0, out_valid=0, drop_cnt=0, state=IDLE; with en=1 the next sample is recorded via ARM with ts=1.

Source files
------------

// File: rtl/nibble_capture_pkg.sv
// nibble_capture_pkg: shared states, default sizes and sample-width helper for the change-capture slice
package nibble_capture_pkg;
  localparam int WIDTH_D = 4;
  localparam int DEPTH_D = 4;
  localparam int TS_W_D = 8;
  localparam int DROP_W_D = 8;
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  function automatic int sample_w(input int width, input int ts_w);
    return 1 + 2 * width + ts_w;
  endfunction
endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: DEPTH-entry first-word-fall-through FIFO; head holds its last value once drained
module capture_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] hold;
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      hold <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        hold <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  // once empty, present the last popped entry instead of stale storage
  assign dout = (level != '0) ? mem[rd_ptr] : hold;
endmodule

// File: rtl/nibble_change_capture.sv
// nibble_change_capture: records timestamped samples that differ from the last recorded one
module nibble_change_capture
  import nibble_capture_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int TS_W = TS_W_D,
  parameter int DROP_W = DROP_W_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flag_i,
  input  logic [WIDTH-1:0]         field_a_i,
  input  logic [WIDTH-1:0]         field_b_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_flag,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        drop_cnt
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int SW = sample_w(WIDTH, TS_W);
  state_t state;
  logic [TS_W-1:0] ts;
  logic [2*WIDTH:0] last, sample;
  logic [SW-1:0] head;
  logic cand, pop, full, push, drop;
  assign sample = {flag_i, field_a_i, field_b_i};
  // en gates the compare so unknown inputs while disabled never reach state
  assign cand = en && (state == ARM || (state == RUN && sample != last));
  assign pop = out_valid & out_ready;
  assign full = level == LW'(DEPTH);
  assign push = cand & (~full | pop);
  assign drop = cand & ~push;
  assign out_valid = level != '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      ts <= '0;
      last <= '0;
      drop_cnt <= '0;
    end else begin
      state <= !en ? IDLE : (state == IDLE ? ARM : RUN);
      ts <= en ? ts + 1'b1 : '0;
      if (push) last <= sample;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  capture_fifo #(.DW(SW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({sample, ts}),
    .dout(head),
    .level(level)
  );
  assign {out_flag, out_a, out_b, out_ts} = head;
endmodule
